// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: debounced single-step / auto-run CPU clock-enable generator with sticky halt.
// Latency: manual step pulse 2 (sync) + DEBOUNCE_CYCLES + 1 clk after the button falls; auto pulse every AUTO_DIV clk.
// No backpressure: HALTED holds cpu_clk_en low until reset. Step counter present only with CPU_CLOCK_CTRL_STEP_COUNT_EN.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step_n,
  input  logic       slide_switch,
  input  logic       halt,
  output logic       cpu_clk_en,
  output logic       run_led,
  output logic       halt_led,
  output logic [7:0] step_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(AUTO_DIV);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic             btn_meta_q, btn_sync_q;
  logic             mode_meta_q, mode_sync_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             btn_stable_q, btn_stable_d;
  logic             btn_prev_q;
  logic             press_evt;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_en_q, clk_en_d;
  logic             run_led_q, halt_led_q;

  // Two-flop synchronizers; button idles high (released), switch idles low (manual).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b1;
      btn_sync_q  <= 1'b1;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_step_n;
      btn_sync_q  <= btn_meta_q;
      mode_meta_q <= slide_switch;
      mode_sync_q <= mode_meta_q;
    end
  end

  // Debounce: accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_cnt_d     = db_cnt_q;
    btn_stable_d = btn_stable_q;
    if (btn_sync_q != btn_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_stable_d = btn_sync_q;
        db_cnt_d     = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Debounce state plus a delayed copy of the stable level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q     <= '0;
      btn_stable_q <= 1'b1;
      btn_prev_q   <= 1'b1;
    end else begin
      db_cnt_q     <= db_cnt_d;
      btn_stable_q <= btn_stable_d;
      btn_prev_q   <= btn_stable_q;
    end
  end

  // A press is the stable level falling; release and holding produce nothing further.
  assign press_evt = btn_prev_q & ~btn_stable_q;

  // Mode FSM and step-pulse decision; halt wins over any pulse source in the same cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    clk_en_d = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else begin
          clk_en_d = press_evt;
          if (mode_sync_q) begin
            state_d = ST_AUTO;
            div_d   = '0;
          end
        end
      end
      ST_AUTO: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else begin
          clk_en_d = (div_q == DIV_LAST);
          div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (!mode_sync_q) begin
            state_d = ST_MANUAL;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // State, divider, registered step pulse and LED decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_MANUAL;
      div_q      <= '0;
      clk_en_q   <= 1'b0;
      run_led_q  <= 1'b0;
      halt_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      clk_en_q   <= clk_en_d;
      run_led_q  <= (state_d == ST_AUTO);
      halt_led_q <= (state_d == ST_HALTED);
    end
  end

  assign cpu_clk_en = clk_en_q;
  assign run_led    = run_led_q;
  assign halt_led   = halt_led_q;

`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
  logic [7:0] step_cnt_q;

  // Count issued steps, updating on the same edge the pulse appears so the value includes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt_q <= 8'h00;
    end else if (clk_en_d) begin
      step_cnt_q <= step_cnt_q + 8'd1;
    end
  end

  assign step_count = step_cnt_q;
`else
  assign step_count = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: randomized stimulus, edge-indexed reference model, scoreboard of expected pulse cycles.
// Latency: the model predicts each pulse at the clk edge it must appear on; the monitor checks at the falling edge.
// No backpressure: every cycle is checked, and the run ends on its own through bounded waits and a watchdog.
module tb_cpu_clock_ctrl;

  localparam int DB = 4;
  localparam int N  = 4;
  localparam int MS_MAN  = 0;
  localparam int MS_AUTO = 1;
  localparam int MS_HALT = 2;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic       btn_step_n   = 1'b1;
  logic       slide_switch = 1'b0;
  logic       halt         = 1'b0;
  logic       cpu_clk_en;
  logic       run_led;
  logic       halt_led;
  logic [7:0] step_count;

  cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DB), .AUTO_DIV(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_step_n   (btn_step_n),
    .slide_switch (slide_switch),
    .halt         (halt),
    .cpu_clk_en   (cpu_clk_en),
    .run_led      (run_led),
    .halt_led     (halt_led),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_q[$];

  // reference model state (values as seen after the latest clk edge)
  bit hb1 = 1'b1, hb2 = 1'b1;   // raw button one / two edges ago
  bit hm1 = 1'b0, hm2 = 1'b0;   // raw switch one / two edges ago
  bit m_stable   = 1'b1;
  int m_run      = 0;
  int fall_edge  = -100;
  int m_state    = MS_MAN;
  int auto_entry = 0;
  int m_pulses   = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int exp_count();
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
    return m_pulses % 256;
`else
    return 0;
`endif
  endfunction

  // Reference model: a pulse is due one edge after the debounced level falls (manual),
  // or every N edges counted from entry to auto; halt is sticky and suppresses everything.
  always @(posedge clk) begin : model
    bit bsync, msync, press, pulse;
    cyc++;
    if (!rst_n) begin
      hb1 = 1'b1; hb2 = 1'b1; hm1 = 1'b0; hm2 = 1'b0;
      m_stable = 1'b1; m_run = 0; fall_edge = -100;
      m_state = MS_MAN; auto_entry = 0; m_pulses = 0;
    end else begin
      bsync = hb2;
      msync = hm2;
      hb2 = hb1; hb1 = btn_step_n;
      hm2 = hm1; hm1 = slide_switch;
      press = (fall_edge == cyc - 1);
      if (bsync != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = bsync;
          m_run = 0;
          if (!bsync) fall_edge = cyc;
        end
      end else begin
        m_run = 0;
      end
      pulse = 1'b0;
      if (m_state != MS_HALT) begin
        if (halt) begin
          m_state = MS_HALT;
        end else if (m_state == MS_MAN) begin
          pulse = press;
          if (msync) begin
            m_state = MS_AUTO;
            auto_entry = cyc;
          end
        end else begin
          pulse = ((cyc - auto_entry) % N == 0);
          if (!msync) m_state = MS_MAN;
        end
      end
      if (pulse) begin
        exp_q.push_back(cyc);
        m_pulses++;
      end
    end
  end

  // Monitor: pop an expected edge whenever the DUT pulses; also check the status outputs.
  always @(negedge clk) begin
    if (cpu_clk_en) begin
      if (exp_q.size() == 0) check("unexpected_pulse", cyc, -1);
      else                   check("pulse_cycle", cyc, exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0] < cyc) check("missed_pulse", -1, exp_q.pop_front());
    check("run_led", int'(run_led), int'(m_state == MS_AUTO));
    check("halt_led", int'(halt_led), int'(m_state == MS_HALT));
    check("step_count", int'(step_count), exp_count());
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int wrap_exp;
`ifdef CPU_CLOCK_CTRL_STEP_COUNT_EN
    wrap_exp = 4;
`else
    wrap_exp = 0;
`endif
    rst_n = 1'b0;
    step(3);
    check("reset_clk_en", int'(cpu_clk_en), 0);
    check("reset_step_count", int'(step_count), 0);
    rst_n = 1'b1;
    step(5);

    // short lows must be treated as glitches
    for (int i = 0; i < 5; i++) begin
      btn_step_n = 1'b0; step(3);
      btn_step_n = 1'b1; step(6);
    end
    check("glitch_step_count", int'(step_count), 0);

    // one long hold gives exactly one step
    btn_step_n = 1'b0; step(20);
    btn_step_n = 1'b1; step(20);

    // random manual button activity
    for (int i = 0; i < 40; i++) begin
      btn_step_n = ~btn_step_n;
      step(int'($urandom_range(1, 9)));
    end
    btn_step_n = 1'b1;
    step(12);

    // auto run with button noise, then back to manual
    slide_switch = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn_step_n = 1'($urandom_range(0, 1));
      step(1);
    end
    btn_step_n = 1'b1;
    slide_switch = 1'b0;
    step(20);

    // halt exactly on a divider terminal-count cycle
    slide_switch = 1'b1;
    step(10);
    for (int i = 0; i < 2 * N + 2; i++) begin
      if (m_state == MS_AUTO && ((cyc + 1 - auto_entry) % N == 0)) break;
      step(1);
    end
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    check("halt_led_after_halt", int'(halt_led), 1);
    for (int i = 0; i < 30; i++) begin
      slide_switch = 1'($urandom_range(0, 1));
      btn_step_n   = 1'($urandom_range(0, 1));
      halt         = 1'($urandom_range(0, 1));
      step(1);
    end
    halt = 1'b0;
    btn_step_n = 1'b1;
    slide_switch = 1'b0;
    step(5);

    // 260 auto pulses wrap the counter
    rst_n = 1'b0; step(2);
    rst_n = 1'b1; step(3);
    slide_switch = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (m_pulses >= 260) break;
      step(1);
    end
    check("auto_pulse_budget", m_pulses, 260);
    check("wrap_step_count", int'(step_count), wrap_exp);

    // reset in the middle of a divide
    step(2);
    rst_n = 1'b0;
    step(1);
    check("midrun_rst_clk_en", int'(cpu_clk_en), 0);
    check("midrun_rst_run_led", int'(run_led), 0);
    check("midrun_rst_halt_led", int'(halt_led), 0);
    check("midrun_rst_step_count", int'(step_count), 0);
    rst_n = 1'b1;
    slide_switch = 1'b0;
    step(3);
    check("post_rst_clk_en", int'(cpu_clk_en), 0);

    // random mixed operation
    for (int i = 0; i < 30; i++) begin
      slide_switch = 1'($urandom_range(0, 1));
      repeat (int'($urandom_range(8, 40))) begin
        if ($urandom_range(0, 5) == 0) btn_step_n = ~btn_step_n;
        halt = ($urandom_range(0, 399) == 0);
        step(1);
      end
      halt = 1'b0;
      if (m_state == MS_HALT) begin
        rst_n = 1'b0; step(1);
        rst_n = 1'b1;
      end
    end
    btn_step_n = 1'b1;
    slide_switch = 1'b0;
    halt = 1'b0;
    step(10);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
